// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Upstream control stage for the multi-stage ALU and the 4-entry register
// file. A RUN request in IDLE latches the low byte of the instruction into IR,
// and the sequencer then steps it through timesteps T1..T3. Every output is a
// Moore decode of (state, IR), so each strobe is stable for a whole state and
// is consumed by the ALU/registers on the following negedge.
//
// Build option:
//   ILLEGAL_OP_EN  - when defined, opcodes 1100-1111 raise Ill during their
//                    single T1 state and set the sticky IllSticky flag, which
//                    clears only on reset. When undefined, those opcodes run
//                    as a one-state NOP and the Ill/IllSticky ports are absent.
//
// Parameters:
//   N          instruction width (must be >= 8); INSTR[N-1:8] is ignored
//
// Ports:
//   CLKb       clock; all state updates on the falling edge
//   RSTb       asynchronous active-low reset
//   Run        start request, sampled only in IDLE
//   INSTR      instruction: [7:4] opcode, [3:2] Rx, [1:0] Ry
//   Busy       high in any state other than IDLE
//   Done       high during the final timestep of an instruction
//   Ain        ALU A-register load
//   Gin        ALU G-register load
//   Gout       ALU result onto the bus
//   FN         ALU function code (non-zero only in T2 of ALU ops)
//   Rin        one-hot register write enable (bit i = Ri)
//   Rout       one-hot register bus drive (bit i = Ri)
//   Extern     external data onto the bus
//   Ill        (ILLEGAL_OP_EN) illegal opcode in T1
//   IllSticky  (ILLEGAL_OP_EN) an illegal opcode has been accepted since reset
// -----------------------------------------------------------------------------
module control_sequencer #(
    parameter int N = 10
) (
    input  logic         CLKb,
    input  logic         RSTb,
    input  logic         Run,
    input  logic [N-1:0] INSTR,
    output logic         Busy,
    output logic         Done,
    output logic         Ain,
    output logic         Gin,
    output logic         Gout,
    output logic [3:0]   FN,
    output logic [3:0]   Rin,
    output logic [3:0]   Rout,
    output logic         Extern
`ifdef ILLEGAL_OP_EN
    ,
    output logic         Ill,
    output logic         IllSticky
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_T1   = 2'd1,
        S_T2   = 2'd2,
        S_T3   = 2'd3
    } state_e;

    // Instruction classes; the class alone decides the state path.
    typedef enum logic [2:0] {
        OP_LOAD,
        OP_MOV,
        OP_BIN,
        OP_UNARY,
        OP_ILL
    } op_class_e;

    function automatic op_class_e classify(input logic [3:0] op);
        op_class_e cls;
        case (op)
            4'b0000:                            cls = OP_LOAD;
            4'b0001:                            cls = OP_MOV;
            4'b0100, 4'b0101:                   cls = OP_UNARY;
            4'b1100, 4'b1101, 4'b1110, 4'b1111: cls = OP_ILL;
            default:                            cls = OP_BIN;
        endcase
        return cls;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    state_e     state_q, state_d;
    logic [7:0] ir_q, ir_d;

    logic       accept;
    logic [3:0] opcode;
    logic [1:0] rx;
    logic [1:0] ry;
    op_class_e  op_class;

    // Only the low byte of INSTR carries meaning; wider builds drop the rest.
    if (N > 8) begin : g_instr_hi
        logic unused_instr_hi;
        assign unused_instr_hi = ^INSTR[N-1:8];
    end

    assign accept   = (state_q == S_IDLE) && Run;
    assign opcode   = ir_q[7:4];
    assign rx       = ir_q[3:2];
    assign ry       = ir_q[1:0];
    assign op_class = classify(opcode);

    // -------------------------------------------------------------------------
    // State and instruction registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of block ordering.
    always_ff @(negedge CLKb or negedge RSTb) begin
        if (!RSTb) begin
            state_q <= S_IDLE;
            ir_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        unique case (state_q)
            S_IDLE: begin
                if (Run) begin
                    ir_d    = INSTR[7:0];
                    state_d = S_T1;
                end
            end
            S_T1: begin
                // LOAD, MOV and illegal opcodes finish in T1; ALU ops continue.
                if (op_class == OP_BIN || op_class == OP_UNARY) begin
                    state_d = S_T2;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_T2:    state_d = S_T3;
            S_T3:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode (Moore: state and IR only)
    // -------------------------------------------------------------------------
    // IDLE drives nothing and reset forces IDLE with IR=0, so all outputs
    // drop to zero as soon as RSTb falls, without waiting for a clock edge.
    always_comb begin
        Busy   = (state_q != S_IDLE);
        Done   = 1'b0;
        Ain    = 1'b0;
        Gin    = 1'b0;
        Gout   = 1'b0;
        FN     = 4'b0000;
        Rin    = 4'b0000;
        Rout   = 4'b0000;
        Extern = 1'b0;
        unique case (state_q)
            S_IDLE: begin
            end
            S_T1: begin
                unique case (op_class)
                    OP_LOAD: begin
                        Extern = 1'b1;
                        Rin    = onehot(rx);
                        Done   = 1'b1;
                    end
                    OP_MOV: begin
                        Rout = onehot(ry);
                        Rin  = onehot(rx);
                        Done = 1'b1;
                    end
                    OP_BIN, OP_UNARY: begin
                        Rout = onehot(rx);
                        Ain  = 1'b1;
                    end
                    OP_ILL: begin
                        Done = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            S_T2: begin
                FN  = opcode;
                Gin = 1'b1;
                // Unary ops have no second operand, so the bus stays undriven.
                if (op_class == OP_BIN) begin
                    Rout = onehot(ry);
                end
            end
            S_T3: begin
                Gout = 1'b1;
                Rin  = onehot(rx);
                Done = 1'b1;
            end
            default: begin
            end
        endcase
    end

`ifdef ILLEGAL_OP_EN
    // -------------------------------------------------------------------------
    // Illegal-opcode reporting
    // -------------------------------------------------------------------------
    logic ill_sticky_q, ill_sticky_d;

    assign Ill = (state_q == S_T1) && (op_class == OP_ILL);

    // The sticky flag sets on the accept edge, so it is already high in the
    // same T1 state where Ill is reported.
    always_comb begin
        ill_sticky_d = ill_sticky_q;
        if (accept && (INSTR[7:6] == 2'b11)) begin
            ill_sticky_d = 1'b1;
        end
    end

    always_ff @(negedge CLKb or negedge RSTb) begin
        if (!RSTb) begin
            ill_sticky_q <= 1'b0;
        end else begin
            ill_sticky_q <= ill_sticky_d;
        end
    end

    assign IllSticky = ill_sticky_q;
`endif

    // -------------------------------------------------------------------------
    // Bus protocol: at most one driver (a register, Extern or the ALU) at once.
    // -------------------------------------------------------------------------
    a_single_bus_driver : assert property (
        @(negedge CLKb) disable iff (!RSTb)
        $countones({Rout, Extern, Gout}) <= 1
    );

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
//
// Directed bench for control_sequencer. A table of per-cycle records gives the
// Run/INSTR inputs presented before a falling clock edge and the outputs
// expected in the state entered on that edge. Hand-written sequences cover
// power-on reset, illegal opcodes, asynchronous reset mid-instruction and the
// first accept after reset release.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

    localparam int N = 10;

    logic         CLKb;
    logic         RSTb;
    logic         Run;
    logic [N-1:0] INSTR;
    logic         Busy, Done, Ain, Gin, Gout, Extern;
    logic [3:0]   FN, Rin, Rout;
`ifdef ILLEGAL_OP_EN
    logic         Ill, IllSticky;
`endif

    control_sequencer #(.N(N)) dut (
        .CLKb   (CLKb),
        .RSTb   (RSTb),
        .Run    (Run),
        .INSTR  (INSTR),
        .Busy   (Busy),
        .Done   (Done),
        .Ain    (Ain),
        .Gin    (Gin),
        .Gout   (Gout),
        .FN     (FN),
        .Rin    (Rin),
        .Rout   (Rout),
        .Extern (Extern)
`ifdef ILLEGAL_OP_EN
        ,
        .Ill       (Ill),
        .IllSticky (IllSticky)
`endif
    );

    initial CLKb = 1'b1;
    always #5 CLKb = ~CLKb;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic         run;
        logic [N-1:0] instr;
        logic         busy;
        logic         done;
        logic         ain;
        logic         gin;
        logic         gout;
        logic         ext;
        logic [3:0]   fn;
        logic [3:0]   rin;
        logic [3:0]   rout;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic run, input logic [N-1:0] instr,
                                input logic busy, input logic done, input logic ain,
                                input logic gin, input logic gout, input logic ext,
                                input logic [3:0] fn, input logic [3:0] rin,
                                input logic [3:0] rout);
        vec_t v;
        v.run = run;   v.instr = instr; v.busy = busy; v.done = done;
        v.ain = ain;   v.gin = gin;     v.gout = gout; v.ext = ext;
        v.fn = fn;     v.rin = rin;     v.rout = rout;
        return v;
    endfunction

    task automatic check_outputs(input string tag, input vec_t v);
        check({tag, ".Busy"},   Busy,   v.busy);
        check({tag, ".Done"},   Done,   v.done);
        check({tag, ".Ain"},    Ain,    v.ain);
        check({tag, ".Gin"},    Gin,    v.gin);
        check({tag, ".Gout"},   Gout,   v.gout);
        check({tag, ".Extern"}, Extern, v.ext);
        check({tag, ".FN"},     FN,     v.fn);
        check({tag, ".Rin"},    Rin,    v.rin);
        check({tag, ".Rout"},   Rout,   v.rout);
        check({tag, ".bus"}, ($countones({Rout, Extern, Gout}) <= 1), 1);
    endtask

    // Apply inputs, let one falling edge pass, sample 1 time unit later.
    task automatic step(input logic run, input logic [N-1:0] instr);
        Run   = run;
        INSTR = instr;
        @(negedge CLKb);
        #1;
    endtask

    vec_t idle_v;

    initial begin
        idle_v = mk(0, 10'h000, 0,0,0,0,0,0, 4'b0000, 4'b0000, 4'b0000);

        // LOAD R2
        vecs.push_back(mk(1, 10'h008, 1,1,0,0,0,1, 4'b0000, 4'b0100, 4'b0000));
        vecs.push_back(mk(0, 10'h008, 0,0,0,0,0,0, 4'b0000, 4'b0000, 4'b0000));
        // LOAD R2 with the ignored upper bits set
        vecs.push_back(mk(1, 10'h308, 1,1,0,0,0,1, 4'b0000, 4'b0100, 4'b0000));
        vecs.push_back(mk(0, 10'h308, 0,0,0,0,0,0, 4'b0000, 4'b0000, 4'b0000));
        // ADD R1,R3
        vecs.push_back(mk(1, 10'h027, 1,0,1,0,0,0, 4'b0000, 4'b0000, 4'b0010));
        vecs.push_back(mk(0, 10'h027, 1,0,0,1,0,0, 4'b0010, 4'b0000, 4'b1000));
        vecs.push_back(mk(0, 10'h027, 1,1,0,0,1,0, 4'b0000, 4'b0010, 4'b0000));
        vecs.push_back(mk(0, 10'h027, 0,0,0,0,0,0, 4'b0000, 4'b0000, 4'b0000));
        // FLP R0 with Run held high: ignored in T1..T3, re-accepted after one IDLE
        vecs.push_back(mk(1, 10'h050, 1,0,1,0,0,0, 4'b0000, 4'b0000, 4'b0001));
        vecs.push_back(mk(1, 10'h050, 1,0,0,1,0,0, 4'b0101, 4'b0000, 4'b0000));
        vecs.push_back(mk(1, 10'h050, 1,1,0,0,1,0, 4'b0000, 4'b0001, 4'b0000));
        vecs.push_back(mk(1, 10'h050, 0,0,0,0,0,0, 4'b0000, 4'b0000, 4'b0000));
        vecs.push_back(mk(1, 10'h050, 1,0,1,0,0,0, 4'b0000, 4'b0000, 4'b0001));
        // INSTR changes mid-flight; IR must hold the FLP
        vecs.push_back(mk(0, 10'h3FF, 1,0,0,1,0,0, 4'b0101, 4'b0000, 4'b0000));
        vecs.push_back(mk(0, 10'h3FF, 1,1,0,0,1,0, 4'b0000, 4'b0001, 4'b0000));
        vecs.push_back(mk(0, 10'h3FF, 0,0,0,0,0,0, 4'b0000, 4'b0000, 4'b0000));
        // Back-to-back MOV R0<-R3 then SUB R0,R1 with Run held high
        vecs.push_back(mk(1, 10'h013, 1,1,0,0,0,0, 4'b0000, 4'b0001, 4'b1000));
        vecs.push_back(mk(1, 10'h031, 0,0,0,0,0,0, 4'b0000, 4'b0000, 4'b0000));
        vecs.push_back(mk(1, 10'h031, 1,0,1,0,0,0, 4'b0000, 4'b0000, 4'b0001));
        vecs.push_back(mk(1, 10'h031, 1,0,0,1,0,0, 4'b0011, 4'b0000, 4'b0010));
        vecs.push_back(mk(1, 10'h031, 1,1,0,0,1,0, 4'b0000, 4'b0001, 4'b0000));
        vecs.push_back(mk(0, 10'h031, 0,0,0,0,0,0, 4'b0000, 4'b0000, 4'b0000));
        // INV R3 (unary)
        vecs.push_back(mk(1, 10'h04C, 1,0,1,0,0,0, 4'b0000, 4'b0000, 4'b1000));
        vecs.push_back(mk(0, 10'h04C, 1,0,0,1,0,0, 4'b0100, 4'b0000, 4'b0000));
        vecs.push_back(mk(0, 10'h04C, 1,1,0,0,1,0, 4'b0000, 4'b1000, 4'b0000));
        vecs.push_back(mk(0, 10'h04C, 0,0,0,0,0,0, 4'b0000, 4'b0000, 4'b0000));
        // Opcode 1011 R1,R2 (highest legal binary op)
        vecs.push_back(mk(1, 10'h0B6, 1,0,1,0,0,0, 4'b0000, 4'b0000, 4'b0010));
        vecs.push_back(mk(0, 10'h0B6, 1,0,0,1,0,0, 4'b1011, 4'b0000, 4'b0100));
        vecs.push_back(mk(0, 10'h0B6, 1,1,0,0,1,0, 4'b0000, 4'b0010, 4'b0000));
        vecs.push_back(mk(0, 10'h0B6, 0,0,0,0,0,0, 4'b0000, 4'b0000, 4'b0000));
        // MOV R2<-R2 self-copy
        vecs.push_back(mk(1, 10'h01A, 1,1,0,0,0,0, 4'b0000, 4'b0100, 4'b0100));
        vecs.push_back(mk(0, 10'h01A, 0,0,0,0,0,0, 4'b0000, 4'b0000, 4'b0000));
        // Illegal opcode 1111: one state, Done only
        vecs.push_back(mk(1, 10'h0F0, 1,1,0,0,0,0, 4'b0000, 4'b0000, 4'b0000));
        vecs.push_back(mk(0, 10'h0F0, 0,0,0,0,0,0, 4'b0000, 4'b0000, 4'b0000));

        // ---------------- power-on reset ----------------
        RSTb  = 1'b0;
        Run   = 1'b0;
        INSTR = '0;
        #2;
        check_outputs("por", idle_v);
`ifdef ILLEGAL_OP_EN
        check("por.Ill", Ill, 0);
        check("por.IllSticky", IllSticky, 0);
`endif
        #10;
        RSTb = 1'b1;   // released between edges (t=12)

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].run, vecs[i].instr);
            check_outputs($sformatf("vec%0d", i), vecs[i]);
        end

`ifdef ILLEGAL_OP_EN
        // ---------------- illegal opcode reporting ----------------
        check("ill.sticky_after", IllSticky, 1);
        step(1, 10'h0C5);
        check("ill.Ill_T1", Ill, 1);
        check("ill.Done_T1", Done, 1);
        check("ill.sticky_T1", IllSticky, 1);
        step(0, 10'h000);
        check("ill.Ill_idle", Ill, 0);
        check("ill.sticky_idle", IllSticky, 1);
`endif

        // ---------------- asynchronous reset mid-T2 of ADD R0,R1 ----------------
        step(1, 10'h021);
        check("rst.T1_Ain", Ain, 1);
        step(0, 10'h021);
        check("rst.T2_Gin", Gin, 1);
        check("rst.T2_Rout", Rout, 4'b0010);
        check("rst.T2_FN", FN, 4'b0010);
        #2;
        RSTb = 1'b0;   // mid-cycle, no clock edge involved
        #1;
        check("rst.async_Gin", Gin, 0);
        check("rst.async_Rout", Rout, 4'b0000);
        check("rst.async_FN", FN, 4'b0000);
        check("rst.async_Busy", Busy, 0);
`ifdef ILLEGAL_OP_EN
        check("rst.async_IllSticky", IllSticky, 0);
`endif
        @(negedge CLKb);
        #1;
        check_outputs("rst.held", idle_v);
        #3;
        RSTb = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step(0, 10'h021);
            check($sformatf("rst.after%0d.Rin", c), Rin, 4'b0000);
            check($sformatf("rst.after%0d.Done", c), Done, 0);
            check($sformatf("rst.after%0d.Busy", c), Busy, 0);
        end

        // ---------------- first accept after release: LOAD R1 ----------------
        step(1, 10'h004);
        check_outputs("rel.T1", mk(1, 10'h004, 1,1,0,0,0,1, 4'b0000, 4'b0010, 4'b0000));
        step(0, 10'h004);
        check_outputs("rel.idle", idle_v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Upstream control stage for MultiStageALU and the 4-entry register file.
- Latches a 10-bit instruction on a RUN request and steps it through timesteps T1..T3.
- Drives the ALU's Ain/Gin/Gout/FN strobes, one-hot register read/write selects, and the external-data enable.
- Pulses Done when the instruction completes.

Parameters:
N, 10, instruction/data width; must be >= 8; bits [N-1:8] of the instruction are ignored.

Ports:
CLKb  input  1  clock; all state updates on negedge CLKb (same edge as the ALU).
RSTb  input  1  asynchronous active-low reset.
Run  input  1  start request; sampled only in IDLE.
INSTR  input  N  instruction: [7:4] opcode, [3:2] Rx, [1:0] Ry.
Busy  output  1  high in any state other than IDLE.
Done  output  1  high during the final timestep of an instruction.
Ain  output  1  ALU A-register load.
Gin  output  1  ALU G-register load.
Gout  output  1  ALU result onto the bus.
FN  output  4  ALU function code.
Rin  output  4  one-hot register write enable (bit i = Ri).
Rout  output  4  one-hot register bus drive (bit i = Ri).
Extern  output  1  external data onto the bus.

Behaviour:
- States: IDLE, T1, T2, T3. Encoding is free; must be fully decoded, with no latches.
- All outputs are Moore, decoded combinationally from state and IR only. They are stable for the whole state and are sampled by the ALU/registers at the next negedge.
- IR (8 bits) loads INSTR[7:0] on negedge when state=IDLE and Run=1; state goes to T1 on the same edge.
- Run in any non-IDLE state is ignored. IR holds until the next accepted Run.
- Opcode decode:
  - 0000 LOAD: T1: Extern=1, Rin[Rx]=1, Done=1 -> IDLE.
  - 0001 MOV: T1: Rout[Ry]=1, Rin[Rx]=1, Done=1 -> IDLE. Rx=Ry is legal (self-copy).
  - 0010/0011/0110/0111/1000/1001/1010/1011 (binary ALU ops):
    - T1: Rout[Rx]=1, Ain=1.
    - T2: Rout[Ry]=1, FN=opcode, Gin=1.
    - T3: Gout=1, Rin[Rx]=1, Done=1 -> IDLE.
  - 0100 INV, 0101 FLP (unary ALU ops):
    - T1: Rout[Rx]=1, Ain=1.
    - T2: FN=opcode, Gin=1, Rout=0000 (bus undriven).
    - T3: Gout=1, Rin[Rx]=1, Done=1 -> IDLE.
  - 1100-1111: illegal; see Optional Feature.
- Default values for any output not listed for a state: 0. FN=0000 except in T2 of ALU ops.
- At most one bus driver at any time: popcount(Rout) + Extern + Gout <= 1. This is an assertion.
- Latency, Run-accept edge to Done state:
  - LOAD/MOV: Done is high in the first state after accept.
  - ALU ops: Done is high in the third state.
- Back-to-back: the earliest next accept is the negedge that ends the Done state + 1, i.e. exactly one IDLE cycle between instructions.
- Reset (RSTb=0, asynchronous, mid-operation included):
  - Takes effect immediately: state=IDLE, IR=0.
  - All outputs go to 0 without waiting for a clock edge: Busy, Done, Ain, Gin, Gout, Extern, Rin, Rout, FN=0000.
- Reset release: the first accept is possible on the first negedge with RSTb=1 and Run=1.
- An in-flight instruction aborted by reset never asserts Rin or Done.

Optional Feature:
- Macro: ILLEGAL_OP_EN.
- Defined:
  - Opcodes 1100-1111 go to T1 with all strobes 0, Done=1, and output Ill=1 (1 bit, same cycle), then return to IDLE.
  - Sticky output IllSticky sets on that negedge and clears only on reset.
- Not defined:
  - Ill and IllSticky ports are absent.
  - Illegal opcodes execute as a NOP: T1 with all strobes 0, Done=1 -> IDLE.

Test Plan:
- Reset mid-T2 of ADD (INSTR=0x0021): assert RSTb=0 while Gin=1 -> Gin, Rout, and FN drop to 0 immediately; after release, Busy=0 and no Rin ever pulses.
- LOAD R2 (INSTR=0x0008), Run for 1 cycle -> T1: Extern=1, Rin=0100, Done=1; next state IDLE with Busy=0.
- ADD R1,R3 (INSTR=0x0027) -> T1: Rout=0010, Ain=1; T2: Rout=1000, FN=0010, Gin=1; T3: Gout=1, Rin=0010, Done=1. With ALU attached, R1=5 and R3=7 give R1=12.
- FLP R0 (INSTR=0x0050) -> T2: Rout=0000, FN=0101, Gin=1; T3: Rin=0001. Run held high through T1..T3 is ignored; a new accept occurs only after one IDLE cycle.
- Back-to-back MOV R0<-R3 (0x0013) then SUB R0,R1 (0x0031) with Run held high -> MOV completes in 1 state, 1 IDLE cycle, SUB completes in 3 states; bus-driver assertion never fires.
- INSTR=0x00F0 with ILLEGAL_OP_EN -> T1: Done=1, Ill=1, IllSticky stays 1 afterward. Without the macro -> T1: Done=1 only, all strobes 0.
